ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Parametrised control sequencer: fetches one instruction over a narrow memory bus in
//  INSTR_W/DATA_W beats with wait states, hands it to the execute/decode stage and waits
//  for completion. Takes interrupts only at instruction boundaries. Sits between the PC
//  unit, the memory interface and the instruction execute stage of the SRP16 core.
// PARAMETERS
//  DATA_W   8        memory data bus width per beat (INSTR_W % DATA_W == 0)
//  INSTR_W  16       instruction width; BEATS = INSTR_W/DATA_W, 1..8
//  ADDR_W   16       address width
//  MAX_WAIT 15       max consecutive mem_ready=0 cycles in one beat before bus error
//  IRQ_VEC  16'h0004 PC loaded on interrupt entry (ADDR_W bits)
// PORTS
//  clk          in  1        clock; all state updates on falling edge
//  reset        in  1        reset, asynchronous, active-high
//  pc_in        in  ADDR_W   current PC from PC unit
//  mem_rd       out 1        fetch read strobe
//  mem_addr     out ADDR_W   fetch address
//  mem_rdata    in  DATA_W   fetch read data
//  mem_ready    in  1        read data valid this cycle
//  instr        out INSTR_W  assembled instruction
//  instr_valid  out 1        instr offered to execute stage
//  exec_ready   in  1        execute stage accepts instr
//  exec_last    in  1        execute stage finishing current instruction
//  exec_pc_wr   in  1        with exec_last: instruction wrote PC (jump/branch taken)
//  pc_inc       out 1        1-cycle pulse: PC += INSTR_W/8
//  pc_load      out 1        1-cycle pulse: PC <= pc_load_val
//  pc_load_val  out ADDR_W   PC load value
//  irq          in  1        level interrupt request
//  irq_en       in  1        interrupt enable
//  irq_ack      out 1        1-cycle pulse on interrupt entry
//  bus_err      out 1        sticky fetch timeout flag
// BEHAVIOUR
//  - All outputs registered. Reset: state=BOUND, beat=0, wait=0, instr=0, all strobes 0,
//    mem_addr=0, pc_load_val=0, bus_err=0. Reset mid-operation aborts immediately.
//  - States BOUND, FETCH, DISPATCH, EXEC, IRQ, ERR.
//  - BOUND (instruction boundary, 1 cycle): if irq&irq_en -> IRQ, else -> FETCH, beat=0.
//  - IRQ (1 cycle): pc_load=1, pc_load_val=IRQ_VEC, irq_ack=1; -> BOUND (irq re-sampled).
//  - FETCH: mem_rd=1, mem_addr=pc_in+beat (mod 2^ADDR_W). At edge with mem_ready=1:
//    instr[beat*DATA_W +: DATA_W] <= mem_rdata (little-endian), wait=0, beat++;
//    after beat BEATS-1 -> DISPATCH. mem_ready=0: wait++; wait reaching MAX_WAIT -> ERR.
//  - DISPATCH: instr_valid=1, instr stable. exec_ready=1 -> EXEC; if exec_last also 1
//    same edge, complete as below and go directly to BOUND.
//  - EXEC: instr_valid=0, instr held. exec_last=1: pc_inc=1 unless exec_pc_wr=1
//    (then no pc_inc); -> BOUND. Latency fetch-to-offer = BEATS + wait cycles.
//  - ERR: bus_err=1, mem_rd=0, all strobes 0; only reset exits.
//  - irq is ignored outside BOUND; irq_en low masks. pc_inc and pc_load never both 1.
//  - exec_last/exec_ready ignored in FETCH, IRQ, ERR, BOUND.
// TESTING
//  1 INSTR_W=16,DATA_W=8, pc_in=0x0100, mem_ready=1, rdata 0x34,0x12 -> addr 0x0100,0x0101,
//    instr=0x1234, instr_valid 2 cycles after BOUND; exec_ready+exec_last -> pc_inc 1 pulse.
//  2 Beat 1 with mem_ready low 3 cycles -> mem_addr held 0x0101, wait cleared, instr correct.
//  3 mem_ready held 0 for 15 cycles -> bus_err=1, mem_rd=0, sticky until reset.
//  4 irq=1,irq_en=1 raised during EXEC -> no effect until exec_last; then pc_load=1,
//    pc_load_val=0x0004, irq_ack=1 pulse, next fetch from pc_in; irq_en=0 -> no entry.
//  5 exec_last with exec_pc_wr=1 -> pc_inc stays 0; pc_in=0xFFFF -> second beat addr 0x0000.
//  6 reset asserted mid-FETCH beat 1 -> all outputs to reset values at once; INSTR_W=32
//    build fetches 4 beats, instr=0xDDCCBBAA from bytes AA,BB,CC,DD.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: fetch bus, execute handshake, PC control and interrupt signals
// of the sequencer; master is the sequencer side.
interface ctrl_sequencer_if #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 16
);
    logic [ADDR_W-1:0]  pc_in;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ready;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               exec_ready;
    logic               exec_last;
    logic               exec_pc_wr;
    logic               pc_inc;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               irq;
    logic               irq_en;
    logic               irq_ack;
    logic               bus_err;

    modport master (
        input  pc_in, mem_rdata, mem_ready, exec_ready, exec_last, exec_pc_wr, irq, irq_en,
        output mem_rd, mem_addr, instr, instr_valid, pc_inc, pc_load, pc_load_val, irq_ack, bus_err
    );
    modport slave (
        output pc_in, mem_rdata, mem_ready, exec_ready, exec_last, exec_pc_wr, irq, irq_en,
        input  mem_rd, mem_addr, instr, instr_valid, pc_inc, pc_load, pc_load_val, irq_ack, bus_err
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetches an instruction in DATA_W beats, offers it to execute, waits for
// completion and takes interrupts only at instruction boundaries. State moves on falling clk.
module ctrl_sequencer #(
    parameter int                DATA_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                ADDR_W   = 16,
    parameter int                MAX_WAIT = 15,
    parameter logic [ADDR_W-1:0] IRQ_VEC  = 'h4
) (
    input logic               clk,
    input logic               reset,
    ctrl_sequencer_if.master  bus
);
    localparam int BEATS = INSTR_W / DATA_W;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int WW    = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {BOUND, FETCH, DISPATCH, EXEC, IRQ, ERR} state_e;

    state_e             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               done;
    logic               mem_rd_q, instr_valid_q, pc_inc_q, pc_load_q, irq_ack_q, bus_err_q;
    logic [ADDR_W-1:0]  mem_addr_q, pc_load_val_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        instr_d = instr_q;
        done    = 1'b0;
        case (state_q)
            BOUND: begin
                state_d = (bus.irq && bus.irq_en) ? IRQ : FETCH;
                beat_d  = '0;
                wait_d  = '0;
            end
            IRQ: state_d = BOUND;
            FETCH: begin
                if (bus.mem_ready) begin
                    instr_d[beat_q*DATA_W +: DATA_W] = bus.mem_rdata;
                    wait_d  = '0;
                    beat_d  = beat_q + 1'b1;
                    state_d = (beat_q == BW'(BEATS - 1)) ? DISPATCH : FETCH;
                end else begin
                    wait_d  = wait_q + 1'b1;
                    state_d = (wait_d == WW'(MAX_WAIT)) ? ERR : FETCH;
                end
            end
            DISPATCH: begin
                done    = bus.exec_ready && bus.exec_last;
                state_d = bus.exec_ready ? (bus.exec_last ? BOUND : EXEC) : DISPATCH;
            end
            EXEC: begin
                done    = bus.exec_last;
                state_d = bus.exec_last ? BOUND : EXEC;
            end
            default: state_d = ERR;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOUND;
            beat_q        <= '0;
            wait_q        <= '0;
            instr_q       <= '0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            irq_ack_q     <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            wait_q        <= wait_d;
            instr_q       <= instr_d;
            mem_rd_q      <= state_d == FETCH;
            mem_addr_q    <= (state_d == FETCH) ? bus.pc_in + ADDR_W'(beat_d) : mem_addr_q;
            instr_valid_q <= state_d == DISPATCH;
            pc_inc_q      <= done && !bus.exec_pc_wr;
            pc_load_q     <= state_d == IRQ;
            pc_load_val_q <= (state_d == IRQ) ? IRQ_VEC : pc_load_val_q;
            irq_ack_q     <= state_d == IRQ;
            bus_err_q     <= state_d == ERR;
        end
    end

    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_load_val = pc_load_val_q;
    assign bus.irq_ack     = irq_ack_q;
    assign bus.bus_err     = bus_err_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed scenarios on 16- and 32-bit builds, then randomized traffic
// against a transaction-level model with a scoreboard monitor.
module tb_ctrl_sequencer;
    logic clk, rst_a, rst_b;
    int   errors, checks, n_instr;
    logic mon_en, prev_v;
    logic [15:0] prev_instr, exp_i;
    logic [2:0]  exp_e;
    logic [15:0] ins_q[$];
    logic [2:0]  ev_q[$];

    ctrl_sequencer_if #(.DATA_W(8), .INSTR_W(16), .ADDR_W(16)) bus_a();
    ctrl_sequencer_if #(.DATA_W(8), .INSTR_W(32), .ADDR_W(16)) bus_b();

    ctrl_sequencer #(.DATA_W(8), .INSTR_W(16), .ADDR_W(16)) dut_a(.clk(clk), .reset(rst_a), .bus(bus_a));
    ctrl_sequencer #(.DATA_W(8), .INSTR_W(32), .ADDR_W(16)) dut_b(.clk(clk), .reset(rst_b), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT offers an instruction or a PC pulse.
    always @(posedge clk) begin
        if (mon_en) begin
            if (bus_a.instr_valid && !prev_v) begin
                checks++;
                n_instr++;
                if (ins_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_instr: got %h with no instruction expected", bus_a.instr);
                end else begin
                    exp_i = ins_q.pop_front();
                    if (bus_a.instr !== exp_i) begin
                        errors++;
                        $display("FAIL sb_instr: got %h expected %h", bus_a.instr, exp_i);
                    end
                end
            end
            if (bus_a.instr_valid && prev_v) begin
                checks++;
                if (bus_a.instr !== prev_instr) begin
                    errors++;
                    $display("FAIL sb_instr_stable: got %h expected %h", bus_a.instr, prev_instr);
                end
            end
            if (bus_a.pc_inc || bus_a.pc_load || bus_a.irq_ack) begin
                checks++;
                exp_e = (ev_q.size() == 0) ? 3'b000 : ev_q.pop_front();
                if ({bus_a.pc_inc, bus_a.pc_load, bus_a.irq_ack} !== exp_e) begin
                    errors++;
                    $display("FAIL sb_pulse inc/load/ack: got %b expected %b",
                             {bus_a.pc_inc, bus_a.pc_load, bus_a.irq_ack}, exp_e);
                end
                if (bus_a.pc_load && bus_a.pc_load_val !== 16'h0004) begin
                    errors++;
                    $display("FAIL sb_pc_load_val: got %h expected 0004", bus_a.pc_load_val);
                end
            end
            prev_v     = bus_a.instr_valid;
            prev_instr = bus_a.instr;
        end else prev_v = 1'b0;
    end

    initial begin
        logic [15:0] pc;
        int bnd_cnt, lows;
        logic is_bnd, in_exec;
        errors = 0; checks = 0; n_instr = 0; mon_en = 0; prev_v = 0;
        rst_a = 1; rst_b = 1;
        {bus_a.pc_in, bus_a.mem_rdata, bus_a.mem_ready, bus_a.exec_ready, bus_a.exec_last,
         bus_a.exec_pc_wr, bus_a.irq, bus_a.irq_en} = '0;
        {bus_b.pc_in, bus_b.mem_rdata, bus_b.mem_ready, bus_b.exec_ready, bus_b.exec_last,
         bus_b.exec_pc_wr, bus_b.irq, bus_b.irq_en} = '0;
        repeat (2) step();
        chk("rst_mem_rd", 32'(bus_a.mem_rd), 0);
        chk("rst_mem_addr", 32'(bus_a.mem_addr), 0);
        chk("rst_instr", 32'(bus_a.instr), 0);
        chk("rst_strobes", 32'({bus_a.instr_valid, bus_a.pc_inc, bus_a.pc_load, bus_a.irq_ack, bus_a.bus_err}), 0);
        chk("rst_pc_load_val", 32'(bus_a.pc_load_val), 0);
        // basic two-beat fetch and completion
        bus_a.pc_in = 16'h0100; bus_a.mem_ready = 1; rst_a = 0;
        step(); chk("t1_rd", 32'(bus_a.mem_rd), 1); chk("t1_addr0", 32'(bus_a.mem_addr), 'h100);
        bus_a.mem_rdata = 8'h34;
        step(); chk("t1_addr1", 32'(bus_a.mem_addr), 'h101); chk("t1_not_valid", 32'(bus_a.instr_valid), 0);
        bus_a.mem_rdata = 8'h12;
        step(); chk("t1_valid", 32'(bus_a.instr_valid), 1); chk("t1_instr", 32'(bus_a.instr), 'h1234);
        chk("t1_rd_off", 32'(bus_a.mem_rd), 0);
        bus_a.exec_ready = 1; bus_a.exec_last = 1;
        step(); chk("t1_pc_inc", 32'(bus_a.pc_inc), 1); chk("t1_valid_off", 32'(bus_a.instr_valid), 0);
        bus_a.exec_ready = 0; bus_a.exec_last = 0; bus_a.pc_in = 16'h0102;
        // wait states on the second beat
        step(); chk("t1_pc_inc_pulse", 32'(bus_a.pc_inc), 0); chk("t2_addr0", 32'(bus_a.mem_addr), 'h102);
        bus_a.mem_rdata = 8'h78;
        step(); chk("t2_addr1", 32'(bus_a.mem_addr), 'h103);
        bus_a.mem_ready = 0;
        repeat (3) begin
            step(); chk("t2_addr_hold", 32'(bus_a.mem_addr), 'h103); chk("t2_hold_valid", 32'(bus_a.instr_valid), 0);
        end
        bus_a.mem_ready = 1; bus_a.mem_rdata = 8'h56;
        step(); chk("t2_valid", 32'(bus_a.instr_valid), 1); chk("t2_instr", 32'(bus_a.instr), 'h5678);
        bus_a.exec_ready = 1;
        // jump: no pc_inc, then address wrap
        step(); chk("t5_exec_valid", 32'(bus_a.instr_valid), 0);
        bus_a.exec_ready = 0; bus_a.exec_last = 1; bus_a.exec_pc_wr = 1; bus_a.pc_in = 16'hFFFF;
        step(); chk("t5_no_pc_inc", 32'(bus_a.pc_inc), 0);
        bus_a.exec_last = 0; bus_a.exec_pc_wr = 0;
        step(); chk("t5_addr_ffff", 32'(bus_a.mem_addr), 'hFFFF); bus_a.mem_rdata = 8'hCD;
        step(); chk("t5_addr_wrap", 32'(bus_a.mem_addr), 'h0000); bus_a.mem_rdata = 8'hAB;
        step(); chk("t5_instr", 32'(bus_a.instr), 'hABCD);
        bus_a.exec_ready = 1;
        // interrupt raised during EXEC is taken only at the boundary
        step(); bus_a.exec_ready = 0; bus_a.irq = 1; bus_a.irq_en = 1;
        step(); chk("t4_no_early_ack", 32'({bus_a.irq_ack, bus_a.pc_load}), 0);
        bus_a.exec_last = 1;
        step(); chk("t4_pc_inc", 32'(bus_a.pc_inc), 1); bus_a.exec_last = 0; bus_a.pc_in = 16'h0200;
        step(); chk("t4_load_ack", 32'({bus_a.pc_load, bus_a.irq_ack, bus_a.pc_inc, bus_a.mem_rd}), 'b1100);
        chk("t4_load_val", 32'(bus_a.pc_load_val), 'h0004);
        bus_a.irq = 0; bus_a.pc_in = 16'h0004;
        step(); chk("t4_pulse_end", 32'({bus_a.pc_load, bus_a.irq_ack}), 0);
        step(); chk("t4_fetch_vec", 32'({bus_a.mem_rd, bus_a.mem_addr}), 'h10004);
        step(); step(); chk("t4_valid", 32'(bus_a.instr_valid), 1);
        bus_a.exec_ready = 1; bus_a.exec_last = 1; bus_a.irq = 1; bus_a.irq_en = 0;
        step(); chk("t4_masked_inc", 32'(bus_a.pc_inc), 1); bus_a.exec_ready = 0; bus_a.exec_last = 0;
        step(); chk("t4_masked", 32'({bus_a.irq_ack, bus_a.mem_rd}), 'b01);
        // fetch timeout
        bus_a.mem_ready = 0; bus_a.irq = 0;
        repeat (14) step();
        chk("t3_before_err", 32'({bus_a.bus_err, bus_a.mem_rd}), 'b01);
        step(); chk("t3_err", 32'({bus_a.bus_err, bus_a.mem_rd}), 'b10);
        bus_a.mem_ready = 1; bus_a.exec_ready = 1; bus_a.exec_last = 1; bus_a.irq = 1; bus_a.irq_en = 1;
        repeat (4) step();
        chk("t3_sticky", 32'({bus_a.bus_err, bus_a.mem_rd, bus_a.pc_load, bus_a.instr_valid, bus_a.pc_inc}), 'b10000);
        {bus_a.exec_ready, bus_a.exec_last, bus_a.irq, bus_a.irq_en} = '0;
        rst_a = 1; #1;
        chk("t6_err_cleared", 32'(bus_a.bus_err), 0);
        // reset in the middle of beat 1
        step(); rst_a = 0; bus_a.pc_in = 16'h0300; bus_a.mem_ready = 1;
        step(); chk("t6_addr0", 32'(bus_a.mem_addr), 'h300); bus_a.mem_rdata = 8'h11;
        step(); chk("t6_addr1", 32'(bus_a.mem_addr), 'h301);
        rst_a = 1; #1;
        chk("t6_abort", 32'({bus_a.mem_rd, bus_a.mem_addr, bus_a.instr}), 0);
        // 32-bit build
        bus_b.pc_in = 16'h0010; bus_b.mem_ready = 1; rst_b = 0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("t6w_addr", 32'(bus_b.mem_addr), 32'(16'h0010 + 16'(i)));
            bus_b.mem_rdata = 8'(8'hAA + 8'(i * 17));
        end
        step(); chk("t6w_valid", 32'(bus_b.instr_valid), 1); chk("t6w_instr", bus_b.instr, 'hDDCCBBAA);
        rst_b = 1;
        // randomized traffic against the transaction model
        step();
        pc = 16'h0100; bnd_cnt = 0; lows = 0; in_exec = 0;
        rst_a = 0; mon_en = 1;
        repeat (3000) begin
            if (bus_a.pc_inc) pc = pc + 16'd2;
            if (bus_a.pc_load) pc = 16'h0004;
            is_bnd = bnd_cnt == 0;
            if (bnd_cnt >= 0) bnd_cnt--;
            bus_a.irq = 1'($urandom_range(0, 1));
            bus_a.irq_en = 1'($urandom_range(0, 1));
            if (is_bnd) begin
                if (bus_a.irq && bus_a.irq_en) begin
                    ev_q.push_back(3'b011);
                    bnd_cnt = 1;
                end else ins_q.push_back({mem_byte(pc + 16'd1), mem_byte(pc)});
            end
            if (bus_a.mem_rd) begin
                bus_a.mem_rdata = mem_byte(bus_a.mem_addr);
                bus_a.mem_ready = (lows >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                lows = bus_a.mem_ready ? 0 : lows + 1;
            end else begin
                bus_a.mem_rdata = 8'($urandom);
                bus_a.mem_ready = 1'($urandom_range(0, 1));
            end
            bus_a.exec_ready = 0; bus_a.exec_last = 0;
            bus_a.exec_pc_wr = 1'($urandom_range(0, 1));
            if (bus_a.instr_valid) begin
                bus_a.exec_ready = 1'($urandom_range(0, 1));
                bus_a.exec_last = bus_a.exec_ready && ($urandom_range(0, 1) != 0);
                in_exec = bus_a.exec_ready && !bus_a.exec_last;
            end else if (in_exec) begin
                bus_a.exec_last = $urandom_range(0, 2) == 0;
                in_exec = !bus_a.exec_last;
            end else if (bus_a.mem_rd) begin
                bus_a.exec_ready = 1'($urandom_range(0, 1));
                bus_a.exec_last = 1'($urandom_range(0, 1));
            end
            if (bus_a.exec_last && (bus_a.instr_valid || bus_a.exec_ready == 0) && !bus_a.mem_rd) begin
                if (bus_a.exec_pc_wr) pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                else ev_q.push_back(3'b100);
                bnd_cnt = 0;
            end
            bus_a.pc_in = pc;
            step();
        end
        mon_en = 0;
        chk("rnd_liveness", 32'(n_instr >= 50), 1);
        chk("rnd_instr_drained", 32'(ins_q.size() <= 1), 1);
        chk("rnd_events_drained", 32'(ev_q.size() <= 1), 1);
        chk("rnd_no_bus_err", 32'(bus_a.bus_err), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
